// File: rtl/sign_compress_if.sv
// Stream interface for sign_compress: 32-bit word input side and
// 16-bit beat output side with first/last/compact framing flags.
interface sign_compress_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;
  logic             out_compact;

  // Producer of words / consumer of beats
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last, out_compact
  );

  // The compressor itself
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last, out_compact
  );
endinterface

// File: rtl/sign_compress.sv
// sign_compress: emits each 32-bit word as one sign-extendable compact
// beat when its upper 17 bits agree, otherwise as low then high half.
// Optional macro SIGN_COMPRESS_STATS_EN adds saturating compact_cnt and
// full_cnt acceptance counters.
module sign_compress #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input logic clk,
  input logic rst,
  sign_compress_if.slave bus
`ifdef SIGN_COMPRESS_STATS_EN
  ,
  output logic [15:0] compact_cnt,
  output logic [15:0] full_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ONE, LO, HI} state_t;

  state_t           state_reg, state_next;
  logic [OUT_W-1:0] data_reg, data_next;
  logic [OUT_W-1:0] hi_reg, hi_next;
  logic             first_reg, first_next;
  logic             last_reg, last_next;
  logic             compact_reg, compact_next;

  logic             out_valid;
  logic             accept;
  logic             word_compact;
  logic [IN_W-OUT_W:0] upper_bits;

  // Sign bit of the low half plus everything above it must agree
  assign upper_bits   = bus.in_data[IN_W-1:OUT_W-1];
  assign word_compact = (&upper_bits) | ~(|upper_bits);

  assign out_valid    = (state_reg != IDLE);
  // A new word may enter while the final beat of the previous one leaves
  assign bus.in_ready = !rst && (!out_valid || (bus.out_ready && last_reg));
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid   = out_valid;
  assign bus.out_data    = data_reg;
  assign bus.out_first   = first_reg;
  assign bus.out_last    = last_reg;
  assign bus.out_compact = compact_reg;

  // Next-state and next-beat selection
  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    hi_next      = hi_reg;
    first_next   = first_reg;
    last_next    = last_reg;
    compact_next = compact_reg;
    case (state_reg)
      LO: begin
        // Second beat of a two-beat word; no new input is taken here
        if (bus.out_ready) begin
          state_next   = HI;
          data_next    = hi_reg;
          first_next   = 1'b0;
          last_next    = 1'b1;
          compact_next = 1'b0;
        end
      end
      default: begin
        // IDLE, ONE, HI: either load a fresh word or drain to IDLE
        if (accept) begin
          data_next  = bus.in_data[OUT_W-1:0];
          first_next = 1'b1;
          if (word_compact) begin
            state_next   = ONE;
            last_next    = 1'b1;
            compact_next = 1'b1;
          end else begin
            state_next   = LO;
            last_next    = 1'b0;
            compact_next = 1'b0;
            hi_next      = bus.in_data[IN_W-1:OUT_W];
          end
        end else if (state_reg != IDLE && bus.out_ready) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // State and output beat registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      hi_reg      <= '0;
      first_reg   <= 1'b0;
      last_reg    <= 1'b0;
      compact_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      hi_reg      <= hi_next;
      first_reg   <= first_next;
      last_reg    <= last_next;
      compact_reg <= compact_next;
    end
  end

`ifdef SIGN_COMPRESS_STATS_EN
  logic [15:0] compact_cnt_reg;
  logic [15:0] full_cnt_reg;

  // Saturating counts of accepted compact and full words
  always_ff @(posedge clk) begin
    if (rst) begin
      compact_cnt_reg <= '0;
      full_cnt_reg    <= '0;
    end else if (accept) begin
      if (word_compact && compact_cnt_reg != 16'hFFFF)
        compact_cnt_reg <= compact_cnt_reg + 16'd1;
      if (!word_compact && full_cnt_reg != 16'hFFFF)
        full_cnt_reg <= full_cnt_reg + 16'd1;
    end
  end

  assign compact_cnt = compact_cnt_reg;
  assign full_cnt    = full_cnt_reg;
`endif

endmodule

// File: doc/sign_compress.md
Name: sign_compress

Overview:
- Streaming inverse of 16→32 sign extension: accepts 32-bit words on a valid/ready interface and emits them as 16-bit beats.
- A word whose upper 17 bits are identical is representable as a signed 16-bit value. It is sent as a single "compact" beat, and the receiver restores it by sign extension.
- Any other word is sent as two beats: low half first, then high half.
- Sits between the datapath and the narrow 16-bit immediate/operand bus.

Parameters:
- IN_W, 32, input word width; must equal 2*OUT_W.
- OUT_W, 16, output beat width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  IN_W  word to compress.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  OUT_W  current beat.
- out_valid  output  1  out_data and the flags are valid.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_first  output  1  beat is the first of its word.
- out_last  output  1  beat is the last of its word.
- out_compact  output  1  single-beat word; the receiver sign-extends out_data[OUT_W-1].

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - state=IDLE; out_valid=0; out_data=0; out_first=0; out_last=0; out_compact=0.
  - Any held word is discarded.
  - in_ready is 0 during the reset cycle.
- Compact test: compact = in_data[IN_W-1:OUT_W-1] all 0s or all 1s (17 bits at default).
- Handshakes:
  - Input accepted on in_valid & in_ready.
  - Output beat consumed on out_valid & out_ready.
  - in_ready = !rst & (!out_valid | (out_ready & out_last)). This allows back-to-back acceptance as the last beat leaves.
  - in_ready does not depend on in_valid.
- States:
  - IDLE: no beat held.
  - ONE: holding a compact beat.
  - LO: holding the low half, high half still stored.
  - HI: holding the high half.
- Accept a compact word, from IDLE or in the cycle the final beat is consumed:
  - Next cycle: out_valid=1, out_data=in_data[OUT_W-1:0], first=1, last=1, compact=1.
  - Next state is ONE.
- Accept a non-compact word:
  - Next cycle: out_data=in_data[OUT_W-1:0], first=1, last=0, compact=0.
  - in_data[IN_W-1:OUT_W] is stored in the high register.
  - Next state is LO.
- LO with beat consumed:
  - Next cycle: out_data=high register, first=0, last=1, compact=0.
  - Next state is HI.
- ONE or HI with beat consumed:
  - If a word is accepted in the same cycle, load it per the two rules above.
  - Otherwise out_valid=0 and state=IDLE.
- Stalls: while out_valid & !out_ready, out_data and all flags are held stable.
- Latency and throughput:
  - First beat appears 1 cycle after input acceptance.
  - Compact words: 1 word/cycle sustained.
  - Non-compact words: 1 word per 2 cycles.
- Boundary cases:
  - 0xFFFF8000 is compact. 0x00008000 is not. 0x00007FFF is compact. 0xFFFF7FFF is not.
  - in_valid while in LO: in_ready=0 and no acceptance.
  - rst in the middle of a two-beat word drops the high half. No beat is emitted after reset until a new acceptance.
  - in_valid dropping has no effect on a word already accepted.

Optional Feature:
- Macro: SIGN_COMPRESS_STATS_EN.
- When defined, two extra output ports are added:
  - compact_cnt (16 bits).
  - full_cnt (16 bits).
- Counting rules:
  - Each increments on acceptance of a compact or non-compact word respectively.
  - Both saturate at 0xFFFF.
  - Both clear to 0 on rst.
- When undefined: the ports and counters are absent, and stream behaviour is identical.

Test Plan:
- Reset, then in_data=0x00001234 with out_ready=1 → one cycle later out_data=0x1234, first=last=compact=1; next cycle out_valid=0.
- in_data=0x12345678 with out_ready=1 → beat 0x5678 (first=1, last=0, compact=0), then beat 0x1234 (first=0, last=1); in_ready=0 during the first beat.
- Back-to-back 0xFFFF8000, 0x00007FFF, 0x00008000 with out_ready held 1 → beats 0x8000(c), 0x7FFF(c), 0x8000(f), 0x0000(l); compact words flow 1 per cycle.
- 0xDEADBEEF with out_ready=0 for 3 cycles → out_data stays 0xBEEF with flags stable; after release, 0xDEAD follows.
- rst asserted while holding 0xBEEF of 0xDEADBEEF → out_valid=0 next cycle; 0xDEAD is never emitted.
- With SIGN_COMPRESS_STATS_EN: send 3 compact and 2 non-compact words → compact_cnt=3, full_cnt=2; after rst both are 0.
